// File: rtl/free_list.sv
// Physical register free list: circular buffer of free PR tags with alloc, free and retired-alloc pointers.
// Define FREELIST_CHECK_EN to add the sticky fl_error occupancy checker output.
module free_list #(
    parameter int unsigned ARCH_COUNT = 32,
    parameter int unsigned PHYS_REGS  = 64,
    parameter int unsigned N          = 3,
    localparam int unsigned PRW       = $clog2(PHYS_REGS),
    localparam int unsigned CAP       = PHYS_REGS - ARCH_COUNT,
    localparam int unsigned CW        = PRW + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N-1:0]       alloc_req,
    output logic [N*PRW-1:0]   alloc_pr,
    output logic               alloc_ok,
    input  logic [N-1:0]       free_en,
    input  logic [N*PRW-1:0]   free_pr,
    input  logic               BPRecoverEN,
    output logic [CW-1:0]      free_count
`ifdef FREELIST_CHECK_EN
    ,
    output logic               fl_error
`endif
);

    localparam int unsigned CW1 = CW + 1;

    logic [CW-1:0]  head_q, head_d;
    logic [CW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  arch_q, arch_d;
    logic [PRW-1:0] entry_q [PHYS_REGS];
    logic [PRW-1:0] entry_d [PHYS_REGS];
    logic [CW-1:0]  alloc_cnt;
    logic [CW-1:0]  free_cnt;

    assign free_count = tail_q - head_q;

    // Each lane reads the entry past all requests in older lanes, requested or not.
    always_comb begin
        alloc_pr  = '0;
        alloc_cnt = '0;
        for (int l = int'(N) - 1; l >= 0; l--) begin
            alloc_pr[l*PRW +: PRW] = entry_q[PRW'(head_q + alloc_cnt)];
            alloc_cnt              = alloc_cnt + CW'(alloc_req[l]);
        end
    end

    // All-or-nothing grant against the start-of-cycle count only.
    assign alloc_ok = (alloc_cnt <= free_count) && !BPRecoverEN;

    always_comb begin
        entry_d  = entry_q;
        free_cnt = '0;
        for (int l = int'(N) - 1; l >= 0; l--) begin
            if (free_en[l]) begin
                entry_d[PRW'(tail_q + free_cnt)] = free_pr[l*PRW +: PRW];
                free_cnt                         = free_cnt + CW'(1);
            end
        end
        tail_d = tail_q + free_cnt;
        arch_d = arch_q + free_cnt;
        head_d = head_q;
        // Recovery rewinds head onto the post-retire arch_head, reclaiming wrong-path tags.
        if (BPRecoverEN) begin
            head_d = arch_d;
        end else if (alloc_ok) begin
            head_d = head_q + alloc_cnt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            arch_q <= '0;
            tail_q <= CW'(CAP);
            for (int unsigned i = 0; i < PHYS_REGS; i++) begin
                entry_q[PRW'(i)] <= (i < CAP) ? PRW'(ARCH_COUNT + i) : '0;
            end
        end else begin
            head_q  <= head_d;
            arch_q  <= arch_d;
            tail_q  <= tail_d;
            entry_q <= entry_d;
        end
    end

`ifdef FREELIST_CHECK_EN
    logic [CW-1:0] grant_cnt;
    logic [CW1-1:0] occ_next;
    logic          fl_error_d;

    // Flag over-free beyond capacity or a grant larger than the free pool.
    always_comb begin
        grant_cnt  = alloc_ok ? alloc_cnt : '0;
        occ_next   = {1'b0, free_count} + {1'b0, free_cnt} - {1'b0, grant_cnt};
        fl_error_d = fl_error | (occ_next > CW1'(CAP)) | (grant_cnt > free_count);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fl_error <= 1'b0;
        end else begin
            fl_error <= fl_error_d;
        end
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// Randomized and directed bench for free_list, checked against a queue-based model of the free pool.
module tb_free_list;

    localparam int N   = 3;
    localparam int PRW = 6;
    localparam int CW  = 7;

    logic             clock = 1'b0;
    logic             reset;
    logic [N-1:0]     alloc_req;
    logic [N*PRW-1:0] alloc_pr;
    logic             alloc_ok;
    logic [N-1:0]     free_en;
    logic [N*PRW-1:0] free_pr;
    logic             BPRecoverEN;
    logic [CW-1:0]    free_count;
`ifdef FREELIST_CHECK_EN
    logic             fl_error;
`endif

    free_list dut (
        .clock      (clock),
        .reset      (reset),
        .alloc_req  (alloc_req),
        .alloc_pr   (alloc_pr),
        .alloc_ok   (alloc_ok),
        .free_en    (free_en),
        .free_pr    (free_pr),
        .BPRecoverEN(BPRecoverEN),
        .free_count (free_count)
`ifdef FREELIST_CHECK_EN
        ,
        .fl_error   (fl_error)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Model: free pool in allocation order, allocated-not-retired tags, and tags held by the arch state.
    int fq[$];
    int ifq[$];
    int held[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int popc(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic model_reset();
        fq.delete();
        ifq.delete();
        held.delete();
        for (int i = 32; i < 64; i++) fq.push_back(i);
        for (int i = 1; i < 32; i++) held.push_back(i);
    endtask

    task automatic do_reset();
        alloc_req   = '0;
        free_en     = '0;
        free_pr     = '0;
        BPRecoverEN = 1'b0;
        reset       = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    // One cycle: drive, check combinational outputs against the model, clock, update the model.
    task automatic step(input logic [N-1:0] req, input logic [N-1:0] fen,
                        input logic [N*PRW-1:0] fpr, input logic rec);
        int   fc;
        int   cnt;
        int   k;
        logic ok;
        alloc_req   = req;
        free_en     = fen;
        free_pr     = fpr;
        BPRecoverEN = rec;
        #1;
        fc  = fq.size();
        cnt = popc(req);
        ok  = (cnt <= fc) && !rec;
        check("free_count", 32'(free_count), fc);
        check("alloc_ok", 32'(alloc_ok), 32'(ok));
        k = 0;
        for (int l = N - 1; l >= 0; l--) begin
            if (k < fc) check($sformatf("alloc_pr[%0d]", l), 32'(alloc_pr[l*PRW +: PRW]), fq[k]);
            if (req[l]) k++;
        end
        @(posedge clock);
        if (ok) for (int i = 0; i < cnt; i++) ifq.push_back(fq.pop_front());
        for (int l = N - 1; l >= 0; l--) begin
            if (fen[l]) begin
                fq.push_back(int'(fpr[l*PRW +: PRW]));
                if (ifq.size() > 0) void'(ifq.pop_front());
            end
        end
        if (rec) begin
            fq = {ifq, fq};
            ifq.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        logic [N-1:0]     req;
        logic [N-1:0]     fen;
        logic [N*PRW-1:0] fpr;
        logic             rec;
        int               rmax;
        int               idx;
        int               ret[$];

        // Reset state and first allocation
        do_reset();
        alloc_req = 3'b111;
        #1;
        check("rst_free_count", 32'(free_count), 32);
        check("rst_pr2", 32'(alloc_pr[2*PRW +: PRW]), 32);
        check("rst_pr1", 32'(alloc_pr[1*PRW +: PRW]), 33);
        check("rst_pr0", 32'(alloc_pr[0 +: PRW]), 34);
        check("rst_ok", 32'(alloc_ok), 1);
`ifdef FREELIST_CHECK_EN
        check("rst_fl_error", 32'(fl_error), 0);
`endif
        step(3'b111, 3'b000, '0, 1'b0);
        alloc_req = 3'b000;
        #1;
        check("after3_free_count", 32'(free_count), 29);

        // Sparse requests
        do_reset();
        alloc_req = 3'b101;
        #1;
        check("sparse_pr0", 32'(alloc_pr[0 +: PRW]), 33);
        step(3'b101, 3'b000, '0, 1'b0);
        alloc_req = 3'b010;
        #1;
        check("sparse_pr1", 32'(alloc_pr[1*PRW +: PRW]), 34);
        step(3'b010, 3'b000, '0, 1'b0);

        // Exhaustion down to two entries, then to empty with a same-cycle free
        do_reset();
        for (int i = 0; i < 10; i++) step(3'b111, 3'b000, '0, 1'b0);
        alloc_req = 3'b111;
        #1;
        check("exh_ok_lo", 32'(alloc_ok), 0);
        step(3'b111, 3'b000, '0, 1'b0);
        step(3'b011, 3'b000, '0, 1'b0);
        fpr = '0;
        fpr[2*PRW +: PRW] = 6'd5;
        step(3'b001, 3'b100, fpr, 1'b0);
        alloc_req = 3'b001;
        free_en   = 3'b000;
        #1;
        check("empty_free_pr0", 32'(alloc_pr[0 +: PRW]), 5);
        check("empty_free_ok", 32'(alloc_ok), 1);
        step(3'b001, 3'b000, '0, 1'b0);

        // Recovery after 9 allocations and 3 retires
        do_reset();
        for (int i = 0; i < 3; i++) step(3'b111, 3'b000, '0, 1'b0);
        fpr = {6'd1, 6'd2, 6'd3};
        step(3'b000, 3'b111, fpr, 1'b0);
        step(3'b000, 3'b000, '0, 1'b1);
        alloc_req = 3'b111;
        #1;
        check("rec_free_count", 32'(free_count), 32);
        check("rec_pr2", 32'(alloc_pr[2*PRW +: PRW]), 35);

        // Randomized traffic with retire, recovery and pointer wrap
        do_reset();
        for (int c = 0; c < 200; c++) begin
            req  = 3'($urandom);
            rec  = ($urandom_range(15) == 0);
            rmax = (ifq.size() < N) ? ifq.size() : N;
            fen  = 3'($urandom);
            for (int l = 0; l < N; l++) if (popc(fen) > rmax) fen[l] = 1'b0;
            fpr = N*PRW'($urandom);
            ret.delete();
            for (int l = N - 1; l >= 0; l--) begin
                if (fen[l]) begin
                    idx = $urandom_range(held.size() - 1);
                    fpr[l*PRW +: PRW] = 6'(held[idx]);
                    held.delete(idx);
                end
            end
            for (int i = 0; i < popc(fen); i++) ret.push_back(ifq[i]);
            step(req, fen, fpr, rec);
            foreach (ret[i]) held.push_back(ret[i]);
            check("fc_le_cap", 32'(free_count <= 7'd32), 1);
        end
`ifdef FREELIST_CHECK_EN
        check("rand_fl_error", 32'(fl_error), 0);
`endif

        // Asynchronous reset in the middle of a cycle
        alloc_req = 3'b111;
        free_en   = 3'b000;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_free_count", 32'(free_count), 32);
        check("midrst_pr2", 32'(alloc_pr[2*PRW +: PRW]), 32);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) step(3'($urandom), 3'b000, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter ARCH_COUNT, default 32, meaning number of architectural registers.
REQ-002 SHALL have parameter PHYS_REGS, default 64, meaning number of physical registers, power of two, greater than ARCH_COUNT.
REQ-003 SHALL have parameter N, default 3, meaning superscalar width; lane N-1 oldest, lane 0 youngest.
REQ-004 SHALL derive PRW = clog2(PHYS_REGS), CAP = PHYS_REGS-ARCH_COUNT and CW = PRW+1.
REQ-005 SHALL have port clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port alloc_req  input  N  per-lane request for a new physical register, from dispatch.
REQ-008 SHALL have port alloc_pr  output  N x PRW  per-lane allocated PR, feeding map-table maptable_new_pr.
REQ-009 SHALL have port alloc_ok  output  1  all requests this cycle are granted.
REQ-010 SHALL have port free_en  input  N  per-lane retire of an instruction with a destination.
REQ-011 SHALL have port free_pr  input  N x PRW  per-lane Told released at retire.
REQ-012 SHALL have port BPRecoverEN  input  1  mispredict recovery, same cycle as the map table's.
REQ-013 SHALL have port free_count  output  CW  number of free entries at start of cycle.

Function
REQ-014 SHALL store free PRs in a circular buffer of PHYS_REGS entries with head (alloc), tail (free) and arch_head (retired-alloc) pointers of CW bits; wrap modulo 2*PHYS_REGS on the pointers, modulo PHYS_REGS on indexing.
REQ-015 SHALL compute free_count = tail - head in CW bits.
REQ-016 SHALL compute alloc_pr[l] combinationally as entry[head + k], where k = number of set alloc_req bits in lanes N-1..l+1; this holds whether or not alloc_req[l] is set.
REQ-017 SHALL assert alloc_ok iff popcount(alloc_req) <= free_count and BPRecoverEN is low; alloc_ok is all-or-nothing, with no partial grant.
REQ-018 SHALL advance head by popcount(alloc_req) at the next edge only when alloc_ok is high; otherwise head holds.
REQ-019 SHALL, per edge, write free_pr of each set free_en lane at tail in order oldest lane first, packed, and advance tail by popcount(free_en).
REQ-020 SHALL advance arch_head by popcount(free_en) per edge, since every retiring destination instruction consumed one allocation.
REQ-021 SHALL use only the start-of-cycle free_count for the alloc_ok decision; a freed PR becomes allocatable one cycle after free_en, with no same-cycle bypass.
REQ-022 SHALL treat simultaneous alloc and free as independent: head and tail both update, and free_count next = free_count - allocs + frees.
REQ-023 SHALL, on BPRecoverEN, apply that cycle's frees, then set head to the updated arch_head; allocation is suppressed that cycle.
REQ-024 SHALL guarantee free_count = CAP the cycle after recovery when no instructions are in flight beyond retire.
REQ-025 SHALL have upstream never request allocation for x0 and never free PR 0; the block does not filter these.
REQ-026 SHALL keep an empty list (free_count=0) legal: alloc_ok is high only when alloc_req=0.

Reset
REQ-027 SHALL, on reset low, asynchronously set head=0, arch_head=0, tail=CAP, and entry[i]=ARCH_COUNT+i for i<CAP (other entries 0).
REQ-028 SHALL present, out of reset with defaults, free_count=32, alloc_pr={lane2:32, lane1:33, lane0:34} when all requests are set, and alloc_ok=1.
REQ-029 SHALL discard all in-flight allocation and free state when reset is asserted mid-operation; release is synchronous to the next clock edge.

Configuration
REQ-030 SHALL, when FREELIST_CHECK_EN is defined, add output fl_error (1 bit, reset 0), sticky-set when free_count + popcount(free_en) - granted allocs would exceed CAP, or when a granted alloc would underflow.
REQ-031 SHALL, when FREELIST_CHECK_EN is undefined, omit the fl_error port and all checking logic, with no other behavioural difference.

Verification
REQ-032 SHALL cover post-reset allocation: alloc_req=3'b111 for 1 cycle -> alloc_pr=32/33/34, alloc_ok=1; next cycle free_count=29.
REQ-033 SHALL cover sparse requests: alloc_req=3'b101 -> lane2=32, lane0=33, head+2; next cycle with alloc_req=3'b010 -> lane1=34.
REQ-034 SHALL cover exhaustion: allocate until free_count=2, then alloc_req=3'b111 -> alloc_ok=0 and head unchanged; alloc_req=3'b011 -> alloc_ok=1.
REQ-035 SHALL cover simultaneous alloc/free at empty: free_count=0, free_en=3'b100 with free_pr=5, and alloc_req=3'b001 -> alloc_ok=0; next cycle alloc_pr[0]=5, alloc_ok=1.
REQ-036 SHALL cover recovery: allocate 9, retire 3 (free_en=3'b111, PRs 1,2,3), then BPRecoverEN with 0 further retires -> next cycle free_count=32 and alloc_pr[2]=35.
REQ-037 SHALL cover pointer wrap: run 200 alloc/free cycles at full width -> every PR 32..63 plus freed tags appears exactly once in circulation; free_count never exceeds 32; fl_error=0 when FREELIST_CHECK_EN is defined.
